// File: rtl/mode_selector_pkg.sv
// Shared types for the mode-selected counter.
//   mode_e  : requested/active counting mode
//   state_e : control FSM states
//   to_mode : maps a raw mode code onto mode_e, reserved codes become MODE_OFF
package mode_selector_pkg;

    localparam int unsigned MODE_W  = 3;
    localparam int unsigned STATE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF    = 3'd0,
        MODE_UP     = 3'd1,
        MODE_DOWN   = 3'd2,
        MODE_BOUNCE = 3'd3,
        MODE_CONST  = 3'd4
    } mode_e;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_SWITCH = 2'd1,
        ST_RUN    = 2'd2
    } state_e;

    // Reserved codes 5-7 behave exactly like OFF.
    function automatic mode_e to_mode(input logic [MODE_W-1:0] raw);
        case (raw)
            MODE_W'(1): return MODE_UP;
            MODE_W'(2): return MODE_DOWN;
            MODE_W'(3): return MODE_BOUNCE;
            MODE_W'(4): return MODE_CONST;
            default:    return MODE_OFF;
        endcase
    endfunction

endpackage

// File: rtl/mode_counter_selector_if.sv
// Mode request handshake plus data stream of the mode-selected counter.
//   mode/mode_valid/mode_ready : mode change request handshake
//   en                         : count enable
//   max_val/const_val          : endpoint and constant value
//   data/data_valid/wrap       : counter output, valid flag, endpoint pulse
// master = the block driving requests, slave = the counter.
interface mode_counter_selector_if
    import mode_selector_pkg::*;
#(
    parameter int unsigned WIDTH = 8
);
    logic [MODE_W-1:0] mode;
    logic              mode_valid;
    logic              mode_ready;
    logic              en;
    logic [WIDTH-1:0]  max_val;
    logic [WIDTH-1:0]  const_val;
    logic [WIDTH-1:0]  data;
    logic              data_valid;
    logic              wrap;

    modport master (
        output mode, mode_valid, en, max_val, const_val,
        input  mode_ready, data, data_valid, wrap
    );

    modport slave (
        input  mode, mode_valid, en, max_val, const_val,
        output mode_ready, data, data_valid, wrap
    );
endinterface

// File: rtl/mode_step_unit.sv
// Combinational next-count logic for one enabled RUN cycle.
//   i_count, i_dir, i_max_val, i_mode : current count, direction/park flag, endpoint, mode
//   o_next_count_c, o_next_dir_c      : count and flag after the step
//   o_hit_c                           : count leaves (or first parks on) an endpoint
// i_dir is the sweep direction in BOUNCE (1 = down). In UP/DOWN it marks that the
// count is parked on its endpoint, so a saturating counter pulses only once.
module mode_step_unit
    import mode_selector_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter bit          WRAP  = 1'b1
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic             i_dir,
    input  logic [WIDTH-1:0] i_max_val,
    input  mode_e            i_mode,
    output logic [WIDTH-1:0] o_next_count_c,
    output logic             o_next_dir_c,
    output logic             o_hit_c
);

    always_comb begin
        o_next_count_c = i_count;
        o_next_dir_c   = i_dir;
        o_hit_c        = 1'b0;
        case (i_mode)
            MODE_UP: begin
                if (i_count < i_max_val) begin
                    o_next_count_c = i_count + WIDTH'(1);
                    o_next_dir_c   = 1'b0;
                end else if (WRAP) begin
                    o_next_count_c = '0;
                    o_next_dir_c   = 1'b0;
                    o_hit_c        = 1'b1;
                end else begin
                    o_next_count_c = i_max_val;
                    o_next_dir_c   = 1'b1;
                    o_hit_c        = !i_dir;
                end
            end
            MODE_DOWN: begin
                // A lowered endpoint pulls the count straight down to it.
                if (i_count > i_max_val) begin
                    o_next_count_c = i_max_val;
                    o_next_dir_c   = 1'b0;
                end else if (i_count != '0) begin
                    o_next_count_c = i_count - WIDTH'(1);
                    o_next_dir_c   = 1'b0;
                end else if (WRAP) begin
                    o_next_count_c = i_max_val;
                    o_next_dir_c   = 1'b0;
                    o_hit_c        = 1'b1;
                end else begin
                    o_next_count_c = '0;
                    o_next_dir_c   = 1'b1;
                    o_hit_c        = !i_dir;
                end
            end
            MODE_BOUNCE: begin
                // Turn at the endpoint by stepping past it, so each endpoint shows once.
                if (!i_dir) begin
                    if (i_count >= i_max_val) begin
                        if (i_max_val == '0) begin
                            o_next_count_c = '0;
                        end else begin
                            o_next_count_c = i_max_val - WIDTH'(1);
                            o_next_dir_c   = 1'b1;
                            o_hit_c        = 1'b1;
                        end
                    end else begin
                        o_next_count_c = i_count + WIDTH'(1);
                    end
                end else begin
                    if (i_count == '0) begin
                        if (i_max_val != '0) begin
                            o_next_count_c = WIDTH'(1);
                            o_next_dir_c   = 1'b0;
                            o_hit_c        = 1'b1;
                        end
                    end else begin
                        o_next_count_c = i_count - WIDTH'(1);
                    end
                end
            end
            default: begin
                o_next_count_c = i_count;
            end
        endcase
    end

endmodule

// File: rtl/mode_counter_selector.sv
// Mode-selected data source: one count register run as OFF/UP/DOWN/BOUNCE/CONST.
//   clk  : clock, all logic on posedge
//   xrst : asynchronous active-low reset
//   bus  : slave side of mode_counter_selector_if (request handshake, en,
//          max_val, const_val in; data, data_valid, wrap, mode_ready out)
// A mode change passes through a one-cycle SWITCH state where data holds and
// the new start value is loaded, so the output never shows a partial step.
module mode_counter_selector
    import mode_selector_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter bit          WRAP  = 1'b1
) (
    input  logic                          clk,
    input  logic                          xrst,
    mode_counter_selector_if.slave        bus
);

    state_e           r_state;
    state_e           w_state_nxt;
    mode_e            r_cur_mode;
    mode_e            w_mode_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic             r_dir;
    logic             w_dir_nxt;
    logic             r_wrap;
    logic             w_wrap_nxt;
    logic             r_data_valid;
    logic             r_mode_ready;
    logic             w_accept;

    logic [WIDTH-1:0] w_step_count;
    logic             w_step_dir;
    logic             w_step_hit;

    mode_step_unit #(
        .WIDTH (WIDTH),
        .WRAP  (WRAP)
    ) u_step (
        .i_count        (r_count),
        .i_dir          (r_dir),
        .i_max_val      (bus.max_val),
        .i_mode         (r_cur_mode),
        .o_next_count_c (w_step_count),
        .o_next_dir_c   (w_step_dir),
        .o_hit_c        (w_step_hit)
    );

    // Next-state and next-register values.
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_cur_mode;
        w_count_nxt = r_count;
        w_dir_nxt   = r_dir;
        w_wrap_nxt  = 1'b0;
        w_accept    = bus.mode_valid && r_mode_ready;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SWITCH;
                    w_mode_nxt  = to_mode(bus.mode);
                end
            end
            ST_SWITCH: begin
                w_dir_nxt = 1'b0;
                case (r_cur_mode)
                    MODE_DOWN:  w_count_nxt = bus.max_val;
                    MODE_CONST: w_count_nxt = bus.const_val;
                    default:    w_count_nxt = '0;
                endcase
                w_state_nxt = (r_cur_mode == MODE_OFF) ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                w_wrap_nxt = bus.en && w_step_hit;
                // An accepted request freezes the count; SWITCH then loads the new start.
                if (w_accept) begin
                    w_state_nxt = ST_SWITCH;
                    w_mode_nxt  = to_mode(bus.mode);
                end else if (bus.en) begin
                    w_count_nxt = w_step_count;
                    w_dir_nxt   = w_step_dir;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            r_state      <= ST_IDLE;
            r_cur_mode   <= MODE_OFF;
            r_count      <= '0;
            r_dir        <= 1'b0;
            r_wrap       <= 1'b0;
            r_data_valid <= 1'b0;
            r_mode_ready <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_cur_mode   <= w_mode_nxt;
            r_count      <= w_count_nxt;
            r_dir        <= w_dir_nxt;
            r_wrap       <= w_wrap_nxt;
            r_data_valid <= (w_state_nxt == ST_RUN);
            r_mode_ready <= (w_state_nxt != ST_SWITCH);
        end
    end

    assign bus.data       = r_count;
    assign bus.data_valid = r_data_valid;
    assign bus.wrap       = r_wrap;
    assign bus.mode_ready = r_mode_ready;

endmodule

// File: tb/tb_mode_counter_selector.sv
// Bench for mode_counter_selector: a wrapping (WRAP=1) and a saturating (WRAP=0)
// instance share one stimulus stream. A cycle model pushes expected outputs per
// instance at each clock edge; a negedge scoreboard pops and compares them.
// Scenario tasks add fixed-value checks taken straight from the intended behaviour.
module tb_mode_counter_selector;
    import mode_selector_pkg::*;

    localparam int unsigned WIDTH = 8;
    typedef logic [WIDTH+2:0] exp_t;   // {data, data_valid, wrap, mode_ready}

    typedef struct {
        int st;       // 0 idle, 1 switch, 2 run
        int md;
        int cnt;
        bit down;
        bit parked;
        bit wrp;
    } mdl_t;

    logic  clk;
    logic  xrst;
    int    n_checks = 0;
    int    n_errors = 0;
    string cur_test = "init";

    mode_counter_selector_if #(.WIDTH(WIDTH)) if_w ();
    mode_counter_selector_if #(.WIDTH(WIDTH)) if_s ();

    assign if_s.mode       = if_w.mode;
    assign if_s.mode_valid = if_w.mode_valid;
    assign if_s.en         = if_w.en;
    assign if_s.max_val    = if_w.max_val;
    assign if_s.const_val  = if_w.const_val;

    mode_counter_selector #(.WIDTH(WIDTH), .WRAP(1'b1)) u_dut_w (
        .clk  (clk),
        .xrst (xrst),
        .bus  (if_w.slave)
    );

    mode_counter_selector #(.WIDTH(WIDTH), .WRAP(1'b0)) u_dut_s (
        .clk  (clk),
        .xrst (xrst),
        .bus  (if_s.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.st = 0; r.md = 0; r.cnt = 0; r.down = 1'b0; r.parked = 1'b0; r.wrp = 1'b0;
        return r;
    endfunction

    function automatic mdl_t mdl_next(input mdl_t s, input bit wrap_p, input int mode,
                                      input bit valid, input bit en, input int m, input int cv);
        mdl_t n;
        bit   accept;
        int   c2;
        bit   d2;
        bit   p2;
        bit   hit;
        n      = s;
        n.wrp  = 1'b0;
        accept = valid && (s.st != 1);
        c2 = s.cnt; d2 = s.down; p2 = s.parked; hit = 1'b0;
        if (s.st == 2 && en) begin
            case (s.md)
                1: begin
                    if (s.cnt < m) begin c2 = s.cnt + 1; p2 = 1'b0; end
                    else if (wrap_p) begin c2 = 0; hit = 1'b1; end
                    else begin c2 = m; hit = !s.parked; p2 = 1'b1; end
                end
                2: begin
                    if (s.cnt > m) begin c2 = m; p2 = 1'b0; end
                    else if (s.cnt > 0) begin c2 = s.cnt - 1; p2 = 1'b0; end
                    else if (wrap_p) begin c2 = m; hit = 1'b1; end
                    else begin c2 = 0; hit = !s.parked; p2 = 1'b1; end
                end
                3: begin
                    if (!s.down) begin
                        if (s.cnt >= m) begin
                            if (m == 0) c2 = 0;
                            else begin c2 = m - 1; d2 = 1'b1; hit = 1'b1; end
                        end else c2 = s.cnt + 1;
                    end else begin
                        if (s.cnt == 0) begin
                            if (m != 0) begin c2 = 1; d2 = 1'b0; hit = 1'b1; end
                        end else c2 = s.cnt - 1;
                    end
                end
                default: c2 = s.cnt;
            endcase
        end
        case (s.st)
            0: if (accept) begin n.st = 1; n.md = (mode <= 4) ? mode : 0; end
            1: begin
                n.down = 1'b0; n.parked = 1'b0;
                n.cnt  = (s.md == 2) ? m : (s.md == 4) ? cv : 0;
                n.st   = (s.md == 0) ? 0 : 2;
            end
            default: begin
                n.wrp = hit;
                if (accept) begin n.st = 1; n.md = (mode <= 4) ? mode : 0; end
                else begin n.cnt = c2; n.down = d2; n.parked = p2; end
            end
        endcase
        return n;
    endfunction

    function automatic exp_t mdl_pack(input mdl_t s);
        return {WIDTH'(s.cnt), (s.st == 2), s.wrp, (s.st != 1)};
    endfunction

    function automatic exp_t mk(input logic [WIDTH-1:0] d, input logic dv, input logic wr, input logic rdy);
        return {d, dv, wr, rdy};
    endfunction

    function automatic exp_t got_w();
        return {if_w.data, if_w.data_valid, if_w.wrap, if_w.mode_ready};
    endfunction

    function automatic exp_t got_s();
        return {if_s.data, if_s.data_valid, if_s.wrap, if_s.mode_ready};
    endfunction

    // ---------------- scoreboard ----------------
    mdl_t m_w;
    mdl_t m_s;
    exp_t q_w[$];
    exp_t q_s[$];
    exp_t e_w;
    exp_t e_s;

    always @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            m_w = mdl_reset();
            m_s = mdl_reset();
            q_w.delete();
            q_s.delete();
        end else begin
            m_w = mdl_next(m_w, 1'b1, int'(if_w.mode), if_w.mode_valid, if_w.en,
                           int'(if_w.max_val), int'(if_w.const_val));
            m_s = mdl_next(m_s, 1'b0, int'(if_w.mode), if_w.mode_valid, if_w.en,
                           int'(if_w.max_val), int'(if_w.const_val));
            q_w.push_back(mdl_pack(m_w));
            q_s.push_back(mdl_pack(m_s));
        end
    end

    always @(negedge clk) begin
        if (q_w.size() > 0) begin
            e_w = q_w.pop_front();
            n_checks++;
            if (got_w() !== e_w) begin
                n_errors++;
                $display("FAIL sb_wrap[%s] t=%0t: got data=%0d dv=%0b wrap=%0b rdy=%0b, expected data=%0d dv=%0b wrap=%0b rdy=%0b",
                         cur_test, $time, if_w.data, if_w.data_valid, if_w.wrap, if_w.mode_ready,
                         e_w[WIDTH+2:3], e_w[2], e_w[1], e_w[0]);
            end
        end
        if (q_s.size() > 0) begin
            e_s = q_s.pop_front();
            n_checks++;
            if (got_s() !== e_s) begin
                n_errors++;
                $display("FAIL sb_sat[%s] t=%0t: got data=%0d dv=%0b wrap=%0b rdy=%0b, expected data=%0d dv=%0b wrap=%0b rdy=%0b",
                         cur_test, $time, if_s.data, if_s.data_valid, if_s.wrap, if_s.mode_ready,
                         e_s[WIDTH+2:3], e_s[2], e_s[1], e_s[0]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [MODE_W-1:0] m);
        if_w.mode       = m;
        if_w.mode_valid = 1'b1;
        tick();
        if_w.mode_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        cur_test = "reset";
        xrst = 1'b0;
        if_w.mode = '0; if_w.mode_valid = 1'b0; if_w.en = 1'b0;
        if_w.max_val = '0; if_w.const_val = '0;
        repeat (3) tick();
        xrst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (got_w() !== mk(8'd0, 1'b0, 1'b0, 1'b1) || got_s() !== mk(8'd0, 1'b0, 1'b0, 1'b1)) begin
                n_errors++;
                $display("FAIL reset_idle[%0d]: got w=%h s=%h expected %h", i, got_w(), got_s(), mk(8'd0, 1'b0, 1'b0, 1'b1));
            end
            tick();
        end
    endtask

    task automatic test_up();
        int ew; int es;
        cur_test = "up";
        if_w.en = 1'b1;
        if_w.max_val = 8'd5;
        req(3'd1);
        tick();
        for (int i = 0; i < 12; i++) begin
            ew = i % 6;
            es = (i < 5) ? i : 5;
            n_checks++;
            if (got_w() !== mk(WIDTH'(ew), 1'b1, (i == 6), 1'b1)) begin
                n_errors++;
                $display("FAIL up_wrap[%0d]: got %h expected %h", i, got_w(), mk(WIDTH'(ew), 1'b1, (i == 6), 1'b1));
            end
            n_checks++;
            if (got_s() !== mk(WIDTH'(es), 1'b1, (i == 6), 1'b1)) begin
                n_errors++;
                $display("FAIL up_sat[%0d]: got %h expected %h", i, got_s(), mk(WIDTH'(es), 1'b1, (i == 6), 1'b1));
            end
            tick();
        end
    endtask

    task automatic test_bounce();
        int seq [11] = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3, 2};
        logic wr;
        cur_test = "bounce";
        if_w.max_val = 8'd3;
        req(3'd3);
        tick();
        for (int i = 0; i < 11; i++) begin
            wr = (i == 4) || (i == 7) || (i == 10);
            n_checks++;
            if (got_w() !== mk(WIDTH'(seq[i]), 1'b1, wr, 1'b1) || got_s() !== got_w()) begin
                n_errors++;
                $display("FAIL bounce3[%0d]: got w=%h s=%h expected %h", i, got_w(), got_s(), mk(WIDTH'(seq[i]), 1'b1, wr, 1'b1));
            end
            tick();
        end
        cur_test = "bounce0";
        if_w.max_val = 8'd0;
        req(3'd3);
        tick();
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (got_w() !== mk(8'd0, 1'b1, 1'b0, 1'b1) || got_s() !== mk(8'd0, 1'b1, 1'b0, 1'b1)) begin
                n_errors++;
                $display("FAIL bounce0[%0d]: got w=%h s=%h expected %h", i, got_w(), got_s(), mk(8'd0, 1'b1, 1'b0, 1'b1));
            end
            tick();
        end
    endtask

    task automatic test_down();
        bit found;
        cur_test = "down";
        if_w.max_val = 8'd255;
        req(3'd2);
        tick();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (got_w() !== mk(WIDTH'(255 - i), 1'b1, 1'b0, 1'b1) || got_s() !== got_w()) begin
                n_errors++;
                $display("FAIL down_start[%0d]: got w=%h s=%h expected %h", i, got_w(), got_s(), mk(WIDTH'(255 - i), 1'b1, 1'b0, 1'b1));
            end
            tick();
        end
        found = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (if_w.data == 8'd200) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL down_reach200: got data=%0d expected 200 within 300 cycles", if_w.data);
        end
        if_w.max_val = 8'd10;
        tick();
        n_checks++;
        if (got_w() !== mk(8'd10, 1'b1, 1'b0, 1'b1) || got_s() !== mk(8'd10, 1'b1, 1'b0, 1'b1)) begin
            n_errors++;
            $display("FAIL down_clamp: got w=%h s=%h expected %h", got_w(), got_s(), mk(8'd10, 1'b1, 1'b0, 1'b1));
        end
        if_w.max_val = 8'd255;
        repeat (10) tick();
        n_checks++;
        if (got_w() !== mk(8'd0, 1'b1, 1'b0, 1'b1) || got_s() !== mk(8'd0, 1'b1, 1'b0, 1'b1)) begin
            n_errors++;
            $display("FAIL down_zero: got w=%h s=%h expected %h", got_w(), got_s(), mk(8'd0, 1'b1, 1'b0, 1'b1));
        end
        tick();
        n_checks++;
        if (got_w() !== mk(8'd255, 1'b1, 1'b1, 1'b1) || got_s() !== mk(8'd0, 1'b1, 1'b1, 1'b1)) begin
            n_errors++;
            $display("FAIL down_endpoint: got w=%h s=%h expected w=%h s=%h", got_w(), got_s(),
                     mk(8'd255, 1'b1, 1'b1, 1'b1), mk(8'd0, 1'b1, 1'b1, 1'b1));
        end
        tick();
        n_checks++;
        if (got_w() !== mk(8'd254, 1'b1, 1'b0, 1'b1) || got_s() !== mk(8'd0, 1'b1, 1'b0, 1'b1)) begin
            n_errors++;
            $display("FAIL down_after: got w=%h s=%h expected w=%h s=%h", got_w(), got_s(),
                     mk(8'd254, 1'b1, 1'b0, 1'b1), mk(8'd0, 1'b1, 1'b0, 1'b1));
        end
    endtask

    task automatic test_handshake();
        cur_test = "handshake";
        if_w.max_val = 8'd200;
        req(3'd1);
        tick();
        repeat (3) tick();
        if_w.const_val  = 8'hA5;
        if_w.mode       = 3'd4;
        if_w.mode_valid = 1'b1;
        tick();
        n_checks++;
        if (got_w() !== mk(8'd3, 1'b0, 1'b0, 1'b0) || got_s() !== got_w()) begin
            n_errors++;
            $display("FAIL hs_switch: got w=%h s=%h expected %h", got_w(), got_s(), mk(8'd3, 1'b0, 1'b0, 1'b0));
        end
        // Held request while not ready must be ignored.
        if_w.mode = 3'd2;
        tick();
        if_w.mode_valid = 1'b0;
        if_w.const_val  = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got_w() !== mk(8'hA5, 1'b1, 1'b0, 1'b1) || got_s() !== got_w()) begin
                n_errors++;
                $display("FAIL hs_const[%0d]: got w=%h s=%h expected %h", i, got_w(), got_s(), mk(8'hA5, 1'b1, 1'b0, 1'b1));
            end
            tick();
        end
    endtask

    task automatic test_endpoint_switch();
        cur_test = "endpoint_switch";
        if_w.max_val = 8'd2;
        req(3'd1);
        tick();
        repeat (2) tick();
        if_w.mode       = 3'd2;
        if_w.mode_valid = 1'b1;
        tick();
        if_w.mode_valid = 1'b0;
        n_checks++;
        if (got_w() !== mk(8'd2, 1'b0, 1'b1, 1'b0) || got_s() !== mk(8'd2, 1'b0, 1'b1, 1'b0)) begin
            n_errors++;
            $display("FAIL ep_switch: got w=%h s=%h expected %h", got_w(), got_s(), mk(8'd2, 1'b0, 1'b1, 1'b0));
        end
        tick();
        n_checks++;
        if (got_w() !== mk(8'd2, 1'b1, 1'b0, 1'b1) || got_s() !== got_w()) begin
            n_errors++;
            $display("FAIL ep_load: got w=%h s=%h expected %h", got_w(), got_s(), mk(8'd2, 1'b1, 1'b0, 1'b1));
        end
        tick();
    endtask

    task automatic test_async_reset();
        cur_test = "async_reset";
        if_w.max_val = 8'd3;
        req(3'd3);
        tick();
        repeat (2) tick();
        #3;
        xrst = 1'b0;
        #1;
        n_checks++;
        if (got_w() !== mk(8'd0, 1'b0, 1'b0, 1'b1) || got_s() !== mk(8'd0, 1'b0, 1'b0, 1'b1)) begin
            n_errors++;
            $display("FAIL async_reset: got w=%h s=%h expected %h", got_w(), got_s(), mk(8'd0, 1'b0, 1'b0, 1'b1));
        end
        repeat (2) tick();
        xrst = 1'b1;
        tick();
        n_checks++;
        if (got_w() !== mk(8'd0, 1'b0, 1'b0, 1'b1) || got_s() !== got_w()) begin
            n_errors++;
            $display("FAIL async_release: got w=%h s=%h expected %h", got_w(), got_s(), mk(8'd0, 1'b0, 1'b0, 1'b1));
        end
    endtask

    task automatic test_reserved();
        cur_test = "reserved";
        if_w.max_val = 8'd5;
        req(3'd1);
        tick();
        repeat (3) tick();
        req(3'd6);
        n_checks++;
        if (got_w() !== mk(8'd3, 1'b0, 1'b0, 1'b0) || got_s() !== got_w()) begin
            n_errors++;
            $display("FAIL rsv_switch: got w=%h s=%h expected %h", got_w(), got_s(), mk(8'd3, 1'b0, 1'b0, 1'b0));
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (got_w() !== mk(8'd0, 1'b0, 1'b0, 1'b1) || got_s() !== got_w()) begin
                n_errors++;
                $display("FAIL rsv_idle[%0d]: got w=%h s=%h expected %h", i, got_w(), got_s(), mk(8'd0, 1'b0, 1'b0, 1'b1));
            end
        end
    endtask

    task automatic test_en_freeze();
        cur_test = "en_freeze";
        if_w.max_val = 8'd5;
        req(3'd1);
        tick();
        repeat (2) tick();
        if_w.en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (got_w() !== mk(8'd2, 1'b1, 1'b0, 1'b1) || got_s() !== got_w()) begin
                n_errors++;
                $display("FAIL en_freeze[%0d]: got w=%h s=%h expected %h", i, got_w(), got_s(), mk(8'd2, 1'b1, 1'b0, 1'b1));
            end
        end
        if_w.const_val = 8'h11;
        req(3'd4);
        tick();
        n_checks++;
        if (got_w() !== mk(8'h11, 1'b1, 1'b0, 1'b1) || got_s() !== got_w()) begin
            n_errors++;
            $display("FAIL en_off_switch: got w=%h s=%h expected %h", got_w(), got_s(), mk(8'h11, 1'b1, 1'b0, 1'b1));
        end
        if_w.en = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_up();
        test_bounce();
        test_down();
        test_handshake();
        test_endpoint_switch();
        test_async_reset();
        test_reserved();
        test_en_freeze();
        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within 200000 time units");
        $fatal(1);
    end

endmodule
